// File: rtl/restrict_mac_if.sv
// Sample/weight/result bundle between the convolution feeder and a restrict_mac element.
// The feeder owns img/ker/val. The MAC owns the accumulated result.
interface restrict_mac_if #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16
);
    logic signed [IMG_WIDTH-1:0]           img;
    logic signed [KER_WIDTH-1:0]           ker;
    logic                                  val;
    logic signed [IMG_WIDTH+KER_WIDTH:0]   result;

    modport master (output img, output ker, output val, input  result);
    modport slave  (input  img, input  ker, input  val, output result);
endinterface

// File: rtl/restrict_mac.sv
// Pipelined signed multiply-accumulate element: capture, retime, multiply, accumulate, register.
// Define RESTRICT_MAC_SATURATE_EN to clamp the accumulator instead of letting it wrap.
module restrict_mac #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    restrict_mac_if.slave  bus
);
    localparam int PW = IMG_WIDTH + KER_WIDTH;
    localparam int AW = PW + 1;

    logic signed [IMG_WIDTH-1:0] img_1p_d, img_1p_q, img_2p_d, img_2p_q;
    logic signed [KER_WIDTH-1:0] ker_1p_d, ker_1p_q, ker_2p_d, ker_2p_q;
    logic signed [PW-1:0]        img_ext, ker_ext;
    logic signed [PW-1:0]        product_3p_d, product_3p_q;
    logic signed [AW-1:0]        acc_4p_d, acc_4p_q;
    logic signed [AW-1:0]        result_d, result_q;
`ifdef RESTRICT_MAC_SATURATE_EN
    logic        [AW:0]          sum_full;
`endif

    always_comb begin
        // A non-valid cycle captures zeros so it contributes a zero product.
        img_1p_d = bus.val ? bus.img : '0;
        ker_1p_d = bus.val ? bus.ker : '0;
        img_2p_d = img_1p_q;
        ker_2p_d = ker_1p_q;

        img_ext      = {{KER_WIDTH{img_2p_q[IMG_WIDTH-1]}}, img_2p_q};
        ker_ext      = {{IMG_WIDTH{ker_2p_q[KER_WIDTH-1]}}, ker_2p_q};
        product_3p_d = img_ext * ker_ext;

`ifdef RESTRICT_MAC_SATURATE_EN
        // One guard bit above the accumulator reveals overflow in either direction.
        sum_full = {acc_4p_q[AW-1], acc_4p_q} + {{2{product_3p_q[PW-1]}}, product_3p_q};
        if (sum_full[AW] != sum_full[AW-1]) begin
            acc_4p_d = sum_full[AW] ? {1'b1, {PW{1'b0}}} : {1'b0, {PW{1'b1}}};
        end else begin
            acc_4p_d = sum_full[AW-1:0];
        end
`else
        acc_4p_d = acc_4p_q + {product_3p_q[PW-1], product_3p_q};
`endif

        result_d = acc_4p_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_1p_q     <= '0;
            ker_1p_q     <= '0;
            img_2p_q     <= '0;
            ker_2p_q     <= '0;
            product_3p_q <= '0;
            acc_4p_q     <= '0;
            result_q     <= '0;
        end else begin
            img_1p_q     <= img_1p_d;
            ker_1p_q     <= ker_1p_d;
            img_2p_q     <= img_2p_d;
            ker_2p_q     <= ker_2p_d;
            product_3p_q <= product_3p_d;
            acc_4p_q     <= acc_4p_d;
            result_q     <= result_d;
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_restrict_mac.sv
// Directed and randomized bench for restrict_mac, checked against a queue-based sum model.
// Build with +define+RESTRICT_MAC_SATURATE_EN to exercise the clamping accumulator.
module tb_restrict_mac;
    logic clk = 1'b0;
    logic rst;

    restrict_mac_if #(.IMG_WIDTH(16), .KER_WIDTH(16)) bus ();
    restrict_mac #(.IMG_WIDTH(16), .KER_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Products waiting to reach the output: a product enters the sum five edges after capture.
    longint pend_q[$];
    longint sum_m;

    localparam longint ACC_MAX = 64'sd4294967295;
    localparam longint ACC_MIN = -64'sd4294967296;

    function automatic longint acc_add(input longint a, input longint p);
        longint s;
        logic [32:0] t;
        s = a + p;
`ifdef RESTRICT_MAC_SATURATE_EN
        if (s > ACC_MAX) s = ACC_MAX;
        if (s < ACC_MIN) s = ACC_MIN;
`else
        t = s[32:0];
        s = longint'($signed(t));
`endif
        return s;
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        sum_m = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            pend_q.push_back(bus.val ? longint'(bus.img) * longint'(bus.ker) : 64'sd0);
            if (pend_q.size() > 4) sum_m = acc_add(sum_m, pend_q.pop_front());
        end
    endtask

    task automatic step(input logic signed [15:0] i, input logic signed [15:0] k, input logic v);
        bus.img = i;
        bus.ker = k;
        bus.val = v;
        @(posedge clk);
        model_edge();
        #1;
        check("result", bus.result, 33'(sum_m));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        model_clear();
        #1;
        check({tag, "_img1"},   33'(dut.img_1p_q),     33'd0);
        check({tag, "_ker2"},   33'(dut.ker_2p_q),     33'd0);
        check({tag, "_prod"},   33'(dut.product_3p_q), 33'd0);
        check({tag, "_acc"},    33'(dut.acc_4p_q),     33'd0);
        check({tag, "_result"}, bus.result,            33'd0);
        step(16'sd1, 16'sd1, 1'b1);
        step(16'sd1, 16'sd1, 1'b1);
        rst = 1'b0;
    endtask

    // Stage-by-stage properties, sampled on the falling edge.
    logic signed [15:0] pv_img2, pv_ker2;
    logic signed [31:0] pv_prod;
    logic signed [32:0] pv_acc;
    logic               pv_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst && pv_valid) begin
            check("stage_prod", 33'(dut.product_3p_q), 33'(longint'(pv_img2) * longint'(pv_ker2)));
            check("stage_acc", dut.acc_4p_q, 33'(acc_add(longint'(pv_acc), longint'(pv_prod))));
        end
        pv_valid = !rst;
        pv_img2  = dut.img_2p_q;
        pv_ker2  = dut.ker_2p_q;
        pv_prod  = dut.product_3p_q;
        pv_acc   = dut.acc_4p_q;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [15:0] ri, rk;
        rst     = 1'b1;
        bus.img = '0;
        bus.ker = '0;
        bus.val = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check("por_result", bus.result, 33'd0);
        rst = 1'b0;

        // Load data into the pipe, then reset between edges.
        step(16'sd3, 16'sd3, 1'b1);
        step(16'sd3, 16'sd3, 1'b1);
        step(16'sd3, 16'sd3, 1'b1);
        reset_pulse("midrst");

        step(16'sd3, 16'sd4, 1'b1);
        idle(4);
        check("first_12", bus.result, 33'd12);
        idle(3);

        step(-16'sd2, 16'sd5, 1'b1);
        idle(4);
        check("second_2", bus.result, 33'd2);

        for (int c = 0; c < 10; c++) step(16'sh7FFF, 16'sh7FFF, 1'b0);
        check("hold_2", bus.result, 33'd2);

        reset_pulse("ovf_rst");
        for (int c = 0; c < 4; c++) step(16'sh8000, 16'sh8000, 1'b1);
        idle(4);
`ifdef RESTRICT_MAC_SATURATE_EN
        check("overflow", bus.result, 33'h0_FFFF_FFFF);
`else
        check("overflow", bus.result, 33'h1_0000_0000);
`endif
        step(16'sd1, -16'sd1, 1'b1);
        idle(5);

        reset_pulse("pre_drop");
        step(16'sd1, 16'sd1, 1'b1);
        step(16'sd1, 16'sd1, 1'b1);
        reset_pulse("drop");
        idle(8);
        check("dropped_0", bus.result, 33'd0);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) reset_pulse("rnd_rst");
            case ($urandom_range(0, 3))
                0:       ri = 16'sh8000;
                1:       ri = 16'sh7FFF;
                default: ri = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rk = 16'sh8000;
                1:       rk = 16'sh7FFF;
                default: rk = 16'($urandom);
            endcase
            step(ri, rk, $urandom_range(0, 3) != 0);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
